// File: rtl/onchip_mem_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_burst_adapter
// Purpose  : Avalon-MM bursting slave front-end for a single-port on-chip RAM
//            with 1-clk read latency. Each read or write burst becomes one RAM
//            word access per cycle on sequential addresses, which wrap modulo
//            2^ADDR_W. Read data returns with s_readdatavalid.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   s_address/s_burstcount       burst start word address / beat count (0 = 1)
//   s_read/s_write               read command / write beat
//   s_writedata/s_byteenable     write beat payload
//   s_waitrequest                high while a read burst is being issued
//   s_readdata/s_readdatavalid   read return
//   m_address/m_byteenable/m_chipselect/m_write/m_writedata -> RAM
//   m_readdata                   RAM q, valid 1 clk after a read issue
// Build option:
//   ONCHIP_MEM_BURST_RDREG_EN    adds a register stage on the read return path
// ============================================================================
module onchip_mem_burst_adapter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int BURST_W = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W-1:0]   s_writedata,
    input  logic [BE_W-1:0]     s_byteenable,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [BE_W-1:0]     m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata
);

    localparam logic [ADDR_W-1:0]  c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] c_cnt_one  = {{(BURST_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W-1:0]    r_addr;       // address of the next beat
    logic [BURST_W-1:0]   r_count;      // beats still to issue/accept
    logic                 r_wr_vld;     // registered write beat issues this cycle
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;
    logic [BE_W-1:0]      r_wr_be;
    logic                 r_rd_pend;    // read issued last cycle, RAM q valid now

    logic [BURST_W-1:0]   w_burst_eff;
    logic                 w_rd_issue;
    logic                 w_wr_accept;
    logic [ADDR_W-1:0]    w_beat_addr;

    assign w_burst_eff   = (s_burstcount == '0) ? c_cnt_one : s_burstcount;
    assign s_waitrequest = !reset_n | (r_state == RD_BURST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        w_wr_accept = 1'b0;
        w_beat_addr = r_addr;
        case (r_state)
            IDLE: begin
                w_beat_addr = s_address;
                // A simultaneous read and write resolves to the write.
                if (s_write) begin
                    w_wr_accept = 1'b1;
                    if (w_burst_eff != c_cnt_one) begin
                        w_state_nxt = WR_BURST;
                    end
                end else if (s_read) begin
                    w_state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                w_rd_issue = 1'b1;
                if (r_count <= c_cnt_one) begin
                    w_state_nxt = IDLE;
                end
            end
            WR_BURST: begin
                // Reads are not accepted while a write burst is open.
                if (s_write) begin
                    w_wr_accept = 1'b1;
                    if (r_count <= c_cnt_one) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Write beats are issued from registers; read beats straight from state.
        // The two never coincide: a read issue needs a read accepted in IDLE
        // the cycle before, which excludes a write accept in that cycle.
        m_chipselect = r_wr_vld | w_rd_issue;
        m_write      = r_wr_vld;
        m_address    = r_wr_vld ? r_wr_addr : (w_rd_issue ? r_addr : '0);
        m_writedata  = r_wr_vld ? r_wr_data : '0;
        m_byteenable = r_wr_vld ? r_wr_be   : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_count   <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_be   <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_wr_vld  <= w_wr_accept;
            r_rd_pend <= w_rd_issue;
            if (w_wr_accept) begin
                r_wr_addr <= w_beat_addr;
                r_wr_data <= s_writedata;
                r_wr_be   <= s_byteenable;
                r_addr    <= w_beat_addr + c_addr_one;
            end
            if (r_state == IDLE && s_write) begin
                r_count <= w_burst_eff - c_cnt_one;
            end else if (r_state == IDLE && s_read) begin
                r_addr  <= s_address;
                r_count <= w_burst_eff;
            end else if (w_rd_issue) begin
                r_addr  <= r_addr + c_addr_one;
                r_count <= r_count - c_cnt_one;
            end else if (w_wr_accept) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

`ifdef ONCHIP_MEM_BURST_RDREG_EN
    logic               r_rd_vld_q;
    logic [DATA_W-1:0]  r_rd_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_vld_q  <= 1'b0;
            r_rd_data_q <= '0;
        end else begin
            r_rd_vld_q  <= r_rd_pend;
            r_rd_data_q <= r_rd_pend ? m_readdata : '0;
        end
    end

    assign s_readdatavalid = r_rd_vld_q;
    assign s_readdata      = r_rd_data_q;
`else
    assign s_readdatavalid = r_rd_pend;
    assign s_readdata      = r_rd_pend ? m_readdata : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_burst_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_onchip_mem_burst_adapter
// Purpose  : Self-checking bench for onchip_mem_burst_adapter. A transaction
//            level model schedules the expected RAM accesses, waitrequest and
//            read returns per cycle; a RAM model provides m_readdata.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_burst_adapter;

`ifdef ONCHIP_MEM_BURST_RDREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] s_address = '0;
    logic [4:0]  s_burstcount = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [3:0]  s_byteenable = '0;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [12:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    onchip_mem_burst_adapter dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_burstcount(s_burstcount),
        .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: address registered, q unregistered.
    logic [31:0] ram [0:8191];
    logic [12:0] ram_aq = '0;
    always @(posedge clk) begin
        if (m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
            end
            ram_aq <= m_address;
        end
    end
    assign m_readdata = ram[ram_aq];

    // Transaction-level model: expectations keyed by cycle number.
    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } beat_t;

    beat_t       exp_m    [int];
    logic [31:0] exp_rd   [int];
    bit          exp_wait [int];
    logic [31:0] ref_mem  [0:8191];

    int tests = 0;
    int fails = 0;

    logic [31:0] cap_rd[$];
    int          cap_rd_cyc[$];
    logic [12:0] cap_addr[$];
    int          wait_cnt = 0;

    logic [31:0] wd_v [16];
    logic [3:0]  be_v [16];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic void clear_cap();
        cap_rd.delete();
        cap_rd_cyc.delete();
        cap_addr.delete();
        wait_cnt = 0;
    endfunction

    function automatic void sched_read(logic [12:0] a, logic [4:0] bc, int t);
        int n;
        logic [12:0] ai;
        n = (bc == 0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            ai = a + 13'(i);
            exp_m[t+1+i]    = '{wr: 1'b0, addr: ai, wd: 32'h0, be: 4'h0};
            exp_wait[t+1+i] = 1'b1;
            exp_rd[t+LAT+i] = ref_mem[ai];
        end
    endfunction

    function automatic void purge(int lim);
        int ks[$];
        foreach (exp_m[k]) if (k >= lim) ks.push_back(k);
        foreach (ks[j]) exp_m.delete(ks[j]);
        ks.delete();
        foreach (exp_rd[k]) if (k >= lim) ks.push_back(k);
        foreach (ks[j]) exp_rd.delete(ks[j]);
        ks.delete();
        foreach (exp_wait[k]) if (k >= lim) ks.push_back(k);
        foreach (ks[j]) exp_wait.delete(ks[j]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [12:0] a, input logic [4:0] bc);
        int n;
        n = (bc == 0) ? 1 : int'(bc);
        sched_read(a, bc, cyc);
        s_read = 1'b1; s_address = a; s_burstcount = bc;
        step();
        s_read = 1'b0;
        repeat (n) step();
    endtask

    // Beats come from wd_v/be_v; a one-cycle gap (with s_read raised, which
    // must be ignored) is inserted before beat index gap_before.
    task automatic do_write(input logic [12:0] a, input logic [4:0] bc,
                            input int gap_before, input bit with_read);
        int n;
        logic [12:0] ai;
        n = (bc == 0) ? 1 : int'(bc);
        for (int k = 0; k < n; k++) begin
            if (k > 0 && k == gap_before) begin
                s_write = 1'b0; s_read = 1'b1;
                step();
                s_read = 1'b0;
            end
            s_write = 1'b1; s_read = (k == 0) ? with_read : 1'b0;
            s_address = a; s_burstcount = bc;
            s_writedata = wd_v[k]; s_byteenable = be_v[k];
            ai = a + 13'(k);
            exp_m[cyc+1] = '{wr: 1'b1, addr: ai, wd: wd_v[k], be: be_v[k]};
            ref_mem[ai] = merge(ref_mem[ai], wd_v[k], be_v[k]);
            step();
        end
        s_write = 1'b0; s_read = 1'b0;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin : cmp
        beat_t e;
        if (!reset_n) begin
            chk("rst_waitrequest", 32'(s_waitrequest), 32'd1);
            chk("rst_chipselect", 32'(m_chipselect), 32'd0);
            chk("rst_write", 32'(m_write), 32'd0);
            chk("rst_address", 32'(m_address), 32'd0);
            chk("rst_valid", 32'(s_readdatavalid), 32'd0);
            chk("rst_readdata", s_readdata, 32'd0);
        end else begin
            chk("waitrequest", 32'(s_waitrequest), 32'(exp_wait.exists(cyc)));
            if (exp_m.exists(cyc)) begin
                e = exp_m[cyc];
                chk("chipselect", 32'(m_chipselect), 32'd1);
                chk("m_write", 32'(m_write), 32'(e.wr));
                chk("m_address", 32'(m_address), 32'(e.addr));
                if (e.wr) begin
                    chk("m_writedata", m_writedata, e.wd);
                    chk("m_byteenable", 32'(m_byteenable), 32'(e.be));
                end
            end else begin
                chk("idle_chipselect", 32'(m_chipselect), 32'd0);
            end
            if (exp_rd.exists(cyc)) begin
                chk("readdatavalid", 32'(s_readdatavalid), 32'd1);
                chk("readdata", s_readdata, exp_rd[cyc]);
            end else begin
                chk("idle_readdatavalid", 32'(s_readdatavalid), 32'd0);
            end
            if (s_readdatavalid) begin
                cap_rd.push_back(s_readdata);
                cap_rd_cyc.push_back(cyc);
            end
            if (m_chipselect && !m_write) cap_addr.push_back(m_address);
            if (s_waitrequest) wait_cnt++;
        end
    end

    initial begin : main
        int t;
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 32'hC3C3_0000 + 32'(i);
            ref_mem[i] = 32'hC3C3_0000 + 32'(i);
        end
        ram[13'h0010]     = 32'hDEADBEEF;
        ref_mem[13'h0010] = 32'hDEADBEEF;

        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: single read
        clear_cap(); t = cyc;
        do_read(13'h0010, 5'd1);
        repeat (3) step();
        chk("t1_nvalid", 32'(cap_rd.size()), 32'd1);
        if (cap_rd.size() == 1) begin
            chk("t1_data", cap_rd[0], 32'hDEADBEEF);
            chk("t1_latency", 32'(cap_rd_cyc[0] - t), 32'(LAT));
            chk("t1_addr", 32'(cap_addr[0]), 32'h0010);
        end

        // 2: read burst 4 across the address wrap
        clear_cap();
        do_read(13'h1FFE, 5'd4);
        repeat (3) step();
        chk("t2_nvalid", 32'(cap_rd.size()), 32'd4);
        chk("t2_wait_cycles", 32'(wait_cnt), 32'd4);
        if (cap_rd.size() == 4 && cap_addr.size() == 4) begin
            chk("t2_addr0", 32'(cap_addr[0]), 32'h1FFE);
            chk("t2_addr2", 32'(cap_addr[2]), 32'h0000);
            chk("t2_addr3", 32'(cap_addr[3]), 32'h0001);
            chk("t2_data0", cap_rd[0], 32'hC3C3_1FFE);
            chk("t2_data2", cap_rd[2], 32'hC3C3_0000);
            chk("t2_contiguous", 32'(cap_rd_cyc[3] - cap_rd_cyc[0]), 32'd3);
        end

        // 3: write burst 3 with a gap and partial byteenable, then read back
        wd_v[0] = 32'h11; be_v[0] = 4'hF;
        wd_v[1] = 32'h22; be_v[1] = 4'h3;
        wd_v[2] = 32'h33; be_v[2] = 4'hF;
        do_write(13'h0100, 5'd3, 1, 1'b0);
        clear_cap();
        do_read(13'h0100, 5'd3);
        repeat (3) step();
        chk("t3_nvalid", 32'(cap_rd.size()), 32'd3);
        if (cap_rd.size() == 3) begin
            chk("t3_data0", cap_rd[0], 32'h0000_0011);
            chk("t3_data1", cap_rd[1], 32'hC3C3_0022);
            chk("t3_data2", cap_rd[2], 32'h0000_0033);
        end

        // 4: write then read same address the next cycle
        wd_v[0] = 32'hA5A5A5A5; be_v[0] = 4'hF;
        do_write(13'h0040, 5'd1, -1, 1'b0);
        clear_cap();
        do_read(13'h0040, 5'd1);
        repeat (3) step();
        chk("t4_nvalid", 32'(cap_rd.size()), 32'd1);
        if (cap_rd.size() == 1) chk("t4_data", cap_rd[0], 32'hA5A5A5A5);

        // read and write together in IDLE: write wins
        wd_v[0] = 32'h12345678; be_v[0] = 4'hF;
        do_write(13'h0200, 5'd1, -1, 1'b1);
        clear_cap();
        do_read(13'h0200, 5'd1);
        repeat (3) step();
        chk("rw_nvalid", 32'(cap_rd.size()), 32'd1);
        if (cap_rd.size() == 1) chk("rw_data", cap_rd[0], 32'h12345678);

        // back-to-back reads: second accepted as soon as the first ends
        clear_cap();
        do_read(13'h0300, 5'd2);
        do_read(13'h0040, 5'd1);
        repeat (3) step();
        chk("b2b_nvalid", 32'(cap_rd.size()), 32'd3);

        // 5: reset in the middle of a read burst of 8
        clear_cap(); t = cyc;
        sched_read(13'h0300, 5'd8, t);
        s_read = 1'b1; s_address = 13'h0300; s_burstcount = 5'd8;
        step();
        s_read = 1'b0;
        repeat (3) step();
        purge(cyc);
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        chk("t5_nvalid_before_rst", 32'(cap_rd.size()), 32'(4 - LAT));
        chk("t5_issued_before_rst", 32'(cap_addr.size()), 32'd3);
        step();
        clear_cap();
        do_read(13'h0010, 5'd1);
        repeat (3) step();
        chk("t5_after_rst_nvalid", 32'(cap_rd.size()), 32'd1);
        if (cap_rd.size() == 1) chk("t5_after_rst_data", cap_rd[0], 32'hDEADBEEF);

        // 6: burstcount 0 behaves as 1
        clear_cap();
        do_read(13'h0040, 5'd0);
        repeat (4) step();
        chk("t6_nissue", 32'(cap_addr.size()), 32'd1);
        chk("t6_nvalid", 32'(cap_rd.size()), 32'd1);
        if (cap_rd.size() == 1) chk("t6_data", cap_rd[0], 32'hA5A5A5A5);

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
